// File: rtl/jetpack_barry_animator_if.sv
// Signal bundle between the jetpack game core and its neighbours
// (thrust input, obstacle generator, video driver).
interface jetpack_barry_animator_if;
  logic        on;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [9:0]  obs1_x;
  logic [9:0]  obs2_x;
  logic [1:0]  obs1_pos;
  logic [1:0]  obs2_pos;
  logic [1:0]  obs1_type;
  logic [1:0]  obs2_type;
  logic [31:0] divided_clocks;
  logic        tick;
  logic [8:0]  y0;
  logic [1:0]  game_state;
  logic        game_over;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  modport master (
    output on, x, y, obs1_x, obs2_x, obs1_pos, obs2_pos, obs1_type, obs2_type,
    input  divided_clocks, tick, y0, game_state, game_over, r, g, b
  );

  modport slave (
    input  on, x, y, obs1_x, obs2_x, obs1_pos, obs2_pos, obs1_type, obs2_type,
    output divided_clocks, tick, y0, game_state, game_over, r, g, b
  );
endinterface

// File: rtl/jetpack_barry_animator.sv
// Jetpack runner game core: clock divider, game tick, Barry motion,
// game state machine with collision detection and per-pixel colour.
module jetpack_barry_animator #(
  parameter int WHICH_CLOCK = 11,
  parameter int MOVE_DIV    = 8
) (
  input  logic CLOCK_50,
  input  logic reset,
  jetpack_barry_animator_if.slave bus
);

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_PLAY  = 2'b01,
    S_OVER  = 2'b10
  } state_t;

  localparam logic [8:0]          Y0_MAX    = 9'd420;
  localparam logic [10:0]         BARRY_X0  = 11'd20;
  localparam logic [10:0]         BARRY_X1  = 11'd50;
  localparam logic [9:0]          BARRY_H   = 10'd60;
  localparam logic [10:0]         OBS_W     = 11'd40;
  localparam logic [9:0]          OBS_H     = 10'd120;
  localparam logic [MOVE_DIV-1:0] MC_ONE    = {{(MOVE_DIV-1){1'b0}}, 1'b1};

  logic [31:0]         r_div;
  logic                r_div_bit;
  logic [MOVE_DIV-1:0] r_move_cnt;
  state_t              r_state;
  logic [8:0]          r_y0;
  logic [7:0]          r_r;
  logic [7:0]          r_g;
  logic [7:0]          r_b;

  logic                w_tick;
  logic                w_move;
  logic                w_collision;
  logic [9:0]          w_y0_top;
  logic [9:0]          w_y0_end;
  logic [10:0]         w_px;
  logic [9:0]          w_py;
  logic                w_in_barry;
  logic                w_in_obs1;
  logic                w_in_obs2;
  logic [23:0]         w_rgb;

  // Lane 3 is not a real lane and is folded onto lane 2.
  function automatic logic [9:0] lane_top(input logic [1:0] pos);
    case (pos)
      2'd0:    return 10'd40;
      2'd1:    return 10'd180;
      default: return 10'd320;
    endcase
  endfunction

  function automatic logic in_obs(input logic [10:0] px, input logic [9:0] py,
                                  input logic [9:0] ox, input logic [1:0] pos,
                                  input logic [1:0] typ);
    logic [10:0] left;
    logic [9:0]  top;
    left = {1'b0, ox};
    top  = lane_top(pos);
    return (typ != 2'd0) && (px >= left) && (px < left + OBS_W) &&
           (py >= top) && (py < top + OBS_H);
  endfunction

  function automatic logic hits_barry(input logic [9:0] ytop, input logic [9:0] yend,
                                      input logic [9:0] ox, input logic [1:0] pos,
                                      input logic [1:0] typ);
    logic [10:0] left;
    logic [9:0]  top;
    left = {1'b0, ox};
    top  = lane_top(pos);
    return (typ != 2'd0) && (BARRY_X0 < left + OBS_W) && (left < BARRY_X1) &&
           (ytop < top + OBS_H) && (top < yend);
  endfunction

  function automatic logic [23:0] obs_colour(input logic [1:0] typ);
    case (typ)
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'hFF8000;
      2'd3:    return 24'h00FFFF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] bg_colour(input state_t st);
    case (st)
      S_START: return 24'h000040;
      S_PLAY:  return 24'h202020;
      S_OVER:  return 24'h800000;
      default: return 24'h000000;
    endcase
  endfunction

  // The tick is the rising edge of one divider bit, seen against its registered copy.
  assign w_tick = r_div[WHICH_CLOCK] & ~r_div_bit;
  assign w_move = w_tick & (&r_move_cnt);

  assign w_y0_top    = {1'b0, r_y0};
  assign w_y0_end    = w_y0_top + BARRY_H;
  assign w_collision = hits_barry(w_y0_top, w_y0_end, bus.obs1_x, bus.obs1_pos, bus.obs1_type) |
                       hits_barry(w_y0_top, w_y0_end, bus.obs2_x, bus.obs2_pos, bus.obs2_type);

  assign w_px       = {1'b0, bus.x};
  assign w_py       = {1'b0, bus.y};
  assign w_in_barry = (w_px >= BARRY_X0) && (w_px < BARRY_X1) &&
                      (w_py >= w_y0_top) && (w_py < w_y0_end);
  assign w_in_obs1  = in_obs(w_px, w_py, bus.obs1_x, bus.obs1_pos, bus.obs1_type);
  assign w_in_obs2  = in_obs(w_px, w_py, bus.obs2_x, bus.obs2_pos, bus.obs2_type);

  // Free-running divider, tick edge detector and move-strobe prescaler.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div      <= 32'd0;
      r_div_bit  <= 1'b0;
      r_move_cnt <= {MOVE_DIV{1'b0}};
    end else begin
      r_div     <= r_div + 32'd1;
      r_div_bit <= r_div[WHICH_CLOCK];
      if (w_tick) begin
        r_move_cnt <= r_move_cnt + MC_ONE;
      end
    end
  end

  // Game state machine; Barry's row only moves while playing.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_START;
      r_y0    <= Y0_MAX;
    end else begin
      case (r_state)
        S_START: begin
          if (bus.on) begin
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_move) begin
            if (bus.on) begin
              if (r_y0 != 9'd0) begin
                r_y0 <= r_y0 - 9'd1;
              end
            end else if (r_y0 != Y0_MAX) begin
              r_y0 <= r_y0 + 9'd1;
            end
          end
          if (w_collision) begin
            r_state <= S_OVER;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_START;
        end
      endcase
    end
  end

  // Pixel priority: off-screen, Barry, obstacle 1, obstacle 2, background.
  always_comb begin
    w_rgb = 24'h000000;
    if ((w_px >= 11'd640) || (w_py >= 10'd480)) begin
      w_rgb = 24'h000000;
    end else if (w_in_barry) begin
      w_rgb = 24'hFFD700;
    end else if (w_in_obs1) begin
      w_rgb = obs_colour(bus.obs1_type);
    end else if (w_in_obs2) begin
      w_rgb = obs_colour(bus.obs2_type);
    end else begin
      w_rgb = bg_colour(r_state);
    end
  end

  // Colour output register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_r <= 8'd0;
      r_g <= 8'd0;
      r_b <= 8'd0;
    end else begin
      r_r <= w_rgb[23:16];
      r_g <= w_rgb[15:8];
      r_b <= w_rgb[7:0];
    end
  end

  assign bus.divided_clocks = r_div;
  assign bus.tick           = w_tick;
  assign bus.y0             = r_y0;
  assign bus.game_state     = r_state;
  assign bus.game_over      = (r_state == S_OVER);
  assign bus.r              = r_r;
  assign bus.g              = r_g;
  assign bus.b              = r_b;

endmodule

// File: tb/tb_jetpack_barry_animator.sv
// Scoreboard bench for the jetpack game core, run with a fast tick
// (WHICH_CLOCK=1, MOVE_DIV=1: tick every 4 cycles, move strobe every 8).
module tb_jetpack_barry_animator;

  localparam int K_DIV   = 0;
  localparam int K_TICK  = 1;
  localparam int K_Y0    = 2;
  localparam int K_STATE = 3;
  localparam int K_OVER  = 4;
  localparam int K_RGB   = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   c0;
  int   total;
  int   bad;
  exp_t sb[$];

  jetpack_barry_animator_if bus();

  jetpack_barry_animator #(.WHICH_CLOCK(1), .MOVE_DIV(1)) u_dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_DIV:   return "divided_clocks";
      K_TICK:  return "tick";
      K_Y0:    return "y0";
      K_STATE: return "game_state";
      K_OVER:  return "game_over";
      K_RGB:   return "rgb";
      default: return "unknown";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [31:0] exp);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: on each falling edge, retire every expectation due by now.
  always @(negedge clk) begin
    logic [31:0] act;
    exp_t        e;
    while ((sb.size() > 0) && (sb[0].due <= cyc)) begin
      e = sb.pop_front();
      case (e.kind)
        K_DIV:   act = bus.divided_clocks;
        K_TICK:  act = {31'd0, bus.tick};
        K_Y0:    act = {23'd0, bus.y0};
        K_STATE: act = {30'd0, bus.game_state};
        K_OVER:  act = {31'd0, bus.game_over};
        K_RGB:   act = {8'd0, bus.r, bus.g, bus.b};
        default: act = 32'hFFFF_FFFF;
      endcase
      chk(kname(e.kind), act, e.exp);
    end
  end

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  // Park just after a move-strobe edge (divider count mod 8 == 7).
  task automatic align();
    for (int n = 0; n < 8; n++) begin
      if (((cyc - c0) % 8) == 7) break;
      adv();
    end
  endtask

  task automatic run_strobes(input int n);
    repeat (8 * n) adv();
  endtask

  task automatic pix(input int px, input int py, input logic [31:0] exp);
    bus.x = px[9:0];
    bus.y = py[8:0];
    push(cyc + 1, K_RGB, exp);
    adv();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, {30'd0, bus.game_state}, 32'd0);
    chk({tag, "_y0"},    {23'd0, bus.y0},         32'd420);
    chk({tag, "_over"},  {31'd0, bus.game_over},  32'd0);
    chk({tag, "_div"},   bus.divided_clocks,      32'd0);
    chk({tag, "_rgb"},   {8'd0, bus.r, bus.g, bus.b}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    c0    = 0;
    reset = 1'b1;
    bus.on = 1'b0;
    bus.x = 10'd0;
    bus.y = 9'd0;
    bus.obs1_x = 10'd0;
    bus.obs2_x = 10'd0;
    bus.obs1_pos = 2'd0;
    bus.obs2_pos = 2'd0;
    bus.obs1_type = 2'd0;
    bus.obs2_type = 2'd0;

    repeat (2) @(negedge clk);
    #1;
    reset_checks("in_reset");
    chk("in_reset_tick", {31'd0, bus.tick}, 32'd0);

    // Divider counts from 0; tick is high only when count mod 4 == 2.
    @(posedge clk);
    #2;
    reset = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      push(c0 + k, K_DIV, k);
      push(c0 + k, K_TICK, ((k % 4) == 2) ? 32'd1 : 32'd0);
    end
    repeat (16) adv();

    // START background, then one-cycle thrust pulse starts the game.
    push(cyc, K_STATE, 32'd0);
    pix(600, 10, 32'h000040);
    bus.on = 1'b1;
    push(cyc + 1, K_STATE, 32'd1);
    adv();
    bus.on = 1'b0;

    align();
    bus.on = 1'b1;
    run_strobes(5);
    push(cyc, K_Y0, 32'd415);
    bus.on = 1'b0;
    run_strobes(10);
    push(cyc, K_Y0, 32'd420);
    bus.on = 1'b1;
    run_strobes(419);
    push(cyc, K_Y0, 32'd1);
    run_strobes(11);
    push(cyc, K_Y0, 32'd0);
    bus.on = 1'b0;
    run_strobes(420);
    push(cyc, K_Y0, 32'd420);
    push(cyc, K_STATE, 32'd1);

    // Touching but not overlapping (obs1_x = 50) is not a collision.
    bus.obs1_type = 2'd1;
    bus.obs1_pos  = 2'd2;
    bus.obs1_x    = 10'd50;
    push(cyc + 1, K_OVER, 32'd0);
    pix(30, 430, 32'hFFD700);

    // Absent obstacle neither collides nor draws.
    bus.obs1_type = 2'd0;
    bus.obs1_x    = 10'd45;
    push(cyc + 1, K_OVER, 32'd0);
    pix(60, 430, 32'h202020);

    bus.obs2_type = 2'd2;
    bus.obs2_pos  = 2'd0;
    bus.obs2_x    = 10'd300;
    pix(310, 50, 32'hFF8000);
    bus.obs1_type = 2'd3;
    bus.obs1_pos  = 2'd0;
    bus.obs1_x    = 10'd300;
    pix(310, 50, 32'h00FFFF);
    pix(339, 159, 32'h00FFFF);
    pix(340, 50, 32'h202020);

    // Real overlap: game over one edge later.
    bus.obs1_type = 2'd1;
    bus.obs1_pos  = 2'd2;
    bus.obs1_x    = 10'd45;
    push(cyc, K_OVER, 32'd0);
    push(cyc + 1, K_OVER, 32'd1);
    push(cyc + 1, K_STATE, 32'd2);
    pix(600, 10, 32'h202020);
    pix(600, 10, 32'h800000);
    pix(700, 10, 32'h000000);
    pix(30, 430, 32'hFFD700);
    pix(60, 330, 32'hFF0000);
    bus.obs2_type = 2'd3;
    bus.obs2_pos  = 2'd3;
    bus.obs2_x    = 10'd500;
    pix(510, 330, 32'h00FFFF);
    pix(510, 200, 32'h800000);
    pix(639, 479, 32'h800000);
    pix(20, 479, 32'hFFD700);
    pix(50, 430, 32'hFF0000);
    pix(100, 480, 32'h000000);

    // Second game: climb to y0 = 300, collide, then reset asynchronously.
    bus.obs1_type = 2'd0;
    bus.obs2_type = 2'd0;
    bus.on = 1'b0;
    reset = 1'b1;
    adv();
    adv();
    reset = 1'b0;
    c0 = cyc;
    align();
    bus.on = 1'b1;
    run_strobes(120);
    push(cyc, K_Y0, 32'd300);
    push(cyc, K_STATE, 32'd1);
    bus.obs1_type = 2'd1;
    bus.obs1_pos  = 2'd2;
    bus.obs1_x    = 10'd45;
    push(cyc + 1, K_STATE, 32'd2);
    push(cyc + 1, K_Y0, 32'd300);
    adv();
    adv();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    reset_checks("async_reset");
    #1;
    reset = 1'b0;
    bus.on = 1'b0;
    repeat (3) adv();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
